instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : PC sequencer with a 2-entry {pc, instr} fetch buffer,
//               branch redirect and sticky misaligned/out-of-range fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam logic [31:0] C_LIMIT = 32'(IMEM_BYTES);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [1:0]  r_count;
    logic [31:0] r_pc0;
    logic [31:0] r_ins0;
    logic [31:0] r_pc1;
    logic [31:0] r_ins1;

    logic        w_pop;
    logic        w_push;
    logic        w_pc_ok;

    assign w_pop   = (r_count != 2'd0) && out_ready;
    assign w_pc_ok = (r_pc < C_LIMIT) && (r_pc[1:0] == 2'b00);
    assign w_push  = (r_state == S_FETCH) && !redirect_valid && w_pc_ok &&
                     ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = (redirect_pc[1:0] != 2'b00) ? S_FAULT : S_FETCH;
        end else if ((r_state == S_FETCH) && !w_pc_ok) begin
            w_state_nxt = S_FAULT;
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_count <= 2'd0;
            r_pc0   <= 32'd0;
            r_ins0  <= 32'd0;
            r_pc1   <= 32'd0;
            r_ins1  <= 32'd0;
        end else if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc <= r_pc + 32'd4;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0  <= r_pc;
                        r_ins0 <= imem_instr;
                    end else begin
                        r_pc1  <= r_pc;
                        r_ins1 <= imem_instr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_pc0   <= r_pc1;
                    r_ins0  <= r_ins1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_pc0  <= r_pc;
                        r_ins0 <= imem_instr;
                    end else begin
                        r_pc0  <= r_pc1;
                        r_ins0 <= r_ins1;
                        r_pc1  <= r_pc;
                        r_ins1 <= imem_instr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr = r_pc[9:0];
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = out_valid ? r_pc0  : 32'd0;
    assign out_instr = out_valid ? r_ins0 : 32'd0;
    assign fault     = (r_state == S_FAULT);

endmodule
`default_nettype wire
